mem_access_stage: RTL and testbench

- MEM stage of the 5-stage pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Performs data-memory loads and stores over a request/acknowledge port with variable latency.
- Stalls upstream stages while an access is outstanding.
- Presents each retired instruction's writeback fields to MEM/WB, with a one-cycle write strobe.

---
 rtl/mem_stage_pkg.sv | 19 +
 rtl/mem_timeout_ctr.sv | 37 +++
 rtl/mem_access_stage.sv | 188 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int unsigned ERR_ALIGN   = 0;
  localparam int unsigned ERR_TIMEOUT = 1;

  localparam logic [31:0] ZERO32 = '0;

  // One spare bit so TIMEOUT-1 always fits, including TIMEOUT=1.
  function automatic int unsigned ctr_width(input int unsigned timeout);
    return $clog2(timeout) + 1;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles without an acknowledge; expire flags the last allowed cycle.
module mem_timeout_ctr
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = ctr_width(TIMEOUT);

  logic [CW-1:0] count_q, count_d;

  assign expire = (count_q == CW'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expire) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues data-memory loads/stores with ack wait and timeout,
// stalls upstream while busy, and hands retired fields to MEM/WB.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              memR_in,
  input  logic              memW_in,
  input  logic [DATA_W-1:0] aluOut_in,
  input  logic [DATA_W-1:0] wrData_in,
  input  logic [4:0]        gprDes_in,
  input  logic              regW_in,
  input  logic              memToR_in,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [4:0]        gprDes_out,
  output logic [DATA_W-1:0] aluOut_out,
  output logic [DATA_W-1:0] memOut_out,
  output logic              regW_out,
  output logic              memToR_out,
  output logic              mwWrite,
  output logic [1:0]        err
);

  state_e            state_q, state_d;
  logic [4:0]        hold_gpr_q, hold_gpr_d;
  logic              hold_regw_q, hold_regw_d;
  logic              hold_mtr_q, hold_mtr_d;
  logic              hold_load_q, hold_load_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [4:0]        gpr_q, gpr_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] mem_q, mem_d;
  logic              regw_q, regw_d;
  logic              mtr_q, mtr_d;
  logic              mw_q, mw_d;
  logic [1:0]        err_q, err_d;
  logic              ctr_clear, ctr_en, expire;
  logic              is_mem, misaligned;

  assign is_mem     = memR_in | memW_in;
  assign misaligned = (aluOut_in[1:0] != 2'b00);

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (ctr_clear),
    .enable (ctr_en),
    .expire (expire)
  );

  always_comb begin
    state_d     = state_q;
    hold_gpr_d  = hold_gpr_q;
    hold_regw_d = hold_regw_q;
    hold_mtr_d  = hold_mtr_q;
    hold_load_d = hold_load_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    gpr_d       = gpr_q;
    alu_d       = alu_q;
    mem_d       = mem_q;
    regw_d      = regw_q;
    mtr_d       = mtr_q;
    mw_d        = 1'b0;
    err_d       = err_q;
    stall       = 1'b0;
    ctr_clear   = 1'b0;
    ctr_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        ctr_clear = 1'b1;
        if (valid_in) begin
          if (!is_mem || misaligned) begin
            gpr_d  = gprDes_in;
            alu_d  = aluOut_in;
            mem_d  = '0;
            regw_d = regW_in & ~is_mem;
            mtr_d  = memToR_in;
            mw_d   = 1'b1;
            if (is_mem) err_d[ERR_ALIGN] = 1'b1;
          end else begin
            stall       = 1'b1;
            hold_gpr_d  = gprDes_in;
            hold_regw_d = regW_in;
            hold_mtr_d  = memToR_in;
            hold_load_d = memR_in & ~memW_in;
            req_d       = 1'b1;
            we_d        = memW_in;
            addr_d      = aluOut_in;
            wdata_d     = wrData_in;
            state_d     = BUSY;
          end
        end
      end
      BUSY: begin
        ctr_en = ~dm_ack;
        // dm_addr doubles as the held ALU result for retirement.
        if (dm_ack || expire) begin
          gpr_d   = hold_gpr_q;
          alu_d   = addr_q;
          mtr_d   = hold_mtr_q;
          mw_d    = 1'b1;
          req_d   = 1'b0;
          state_d = IDLE;
          if (dm_ack) begin
            mem_d  = hold_load_q ? dm_rdata : '0;
            regw_d = hold_regw_q;
          end else begin
            mem_d              = '0;
            regw_d             = 1'b0;
            err_d[ERR_TIMEOUT] = 1'b1;
          end
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_gpr_q  <= '0;
      hold_regw_q <= 1'b0;
      hold_mtr_q  <= 1'b0;
      hold_load_q <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gpr_q       <= '0;
      alu_q       <= '0;
      mem_q       <= '0;
      regw_q      <= 1'b0;
      mtr_q       <= 1'b0;
      mw_q        <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_gpr_q  <= hold_gpr_d;
      hold_regw_q <= hold_regw_d;
      hold_mtr_q  <= hold_mtr_d;
      hold_load_q <= hold_load_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      gpr_q       <= gpr_d;
      alu_q       <= alu_d;
      mem_q       <= mem_d;
      regw_q      <= regw_d;
      mtr_q       <= mtr_d;
      mw_q        <= mw_d;
      err_q       <= err_d;
    end
  end

  assign dm_req     = req_q;
  assign dm_we      = we_q;
  assign dm_addr    = addr_q;
  assign dm_wdata   = wdata_q;
  assign gprDes_out = gpr_q;
  assign aluOut_out = alu_q;
  assign memOut_out = mem_q;
  assign regW_out   = regw_q;
  assign memToR_out = mtr_q;
  assign mwWrite    = mw_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios then random instructions
// checked against a transaction-level expectation of each retirement.
module tb_mem_access_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, memR_in, memW_in, regW_in, memToR_in;
  logic [31:0] aluOut_in, wrData_in;
  logic [4:0]  gprDes_in;
  logic        stall, dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [4:0]  gprDes_out;
  logic [31:0] aluOut_out, memOut_out;
  logic        regW_out, memToR_out, mwWrite;
  logic [1:0]  err;

  int checks   = 0;
  int failures = 0;

  logic [4:0]  exp_gpr;
  logic [31:0] exp_alu, exp_mem;
  logic        exp_regw, exp_mtr;
  logic [1:0]  exp_err;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TO), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .memR_in    (memR_in),
    .memW_in    (memW_in),
    .aluOut_in  (aluOut_in),
    .wrData_in  (wrData_in),
    .gprDes_in  (gprDes_in),
    .regW_in    (regW_in),
    .memToR_in  (memToR_in),
    .stall      (stall),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_ack     (dm_ack),
    .dm_rdata   (dm_rdata),
    .gprDes_out (gprDes_out),
    .aluOut_out (aluOut_out),
    .memOut_out (memOut_out),
    .regW_out   (regW_out),
    .memToR_out (memToR_out),
    .mwWrite    (mwWrite),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_wb(input logic mw);
    chk("mwWrite",    mwWrite,    mw);
    chk("gprDes_out", gprDes_out, exp_gpr);
    chk("aluOut_out", aluOut_out, exp_alu);
    chk("memOut_out", memOut_out, exp_mem);
    chk("regW_out",   regW_out,   exp_regw);
    chk("memToR_out", memToR_out, exp_mtr);
    chk("err",        err,        exp_err);
  endtask

  task automatic model_reset();
    exp_gpr = '0; exp_alu = '0; exp_mem = '0;
    exp_regw = 1'b0; exp_mtr = 1'b0; exp_err = '0;
  endtask

  task automatic idle(input logic ack);
    valid_in = 1'b0;
    dm_ack   = ack;
    dm_rdata = $urandom;
    @(negedge clk);
    chk("idle_stall", stall, 1'b0);
    chk("idle_req", dm_req, 1'b0);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    check_wb(1'b0);
  endtask

  // ack_at: BUSY cycle (1-based) carrying dm_ack; beyond TO means no ack.
  task automatic run_instr(input logic r, input logic w, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] gpr,
                           input logic rw, input logic mtr,
                           input int unsigned ack_at, input logic [31:0] rdata);
    logic is_mem, mis, acked;
    is_mem = r | w;
    mis    = is_mem && (addr % 4 != 0);
    acked  = 1'b0;
    valid_in = 1'b1; memR_in = r; memW_in = w; aluOut_in = addr; wrData_in = wdata;
    gprDes_in = gpr; regW_in = rw; memToR_in = mtr; dm_ack = 1'b0;
    @(negedge clk);
    chk("issue_stall", stall, is_mem && !mis);
    chk("issue_req", dm_req, 1'b0);
    @(posedge clk); #1;
    exp_gpr = gpr; exp_alu = addr; exp_mtr = mtr;
    if (!is_mem || mis) begin
      exp_mem  = '0;
      exp_regw = mis ? 1'b0 : rw;
      if (mis) exp_err[0] = 1'b1;
    end else begin
      valid_in = 1'b1; memR_in = 1'($urandom); memW_in = 1'($urandom);
      aluOut_in = $urandom; wrData_in = $urandom; gprDes_in = 5'($urandom);
      regW_in = 1'($urandom); memToR_in = 1'($urandom);
      for (int unsigned b = 1; b <= TO; b++) begin
        dm_ack   = (b == ack_at);
        dm_rdata = (b == ack_at) ? rdata : $urandom;
        @(negedge clk);
        chk("busy_req", dm_req, 1'b1);
        chk("busy_we", dm_we, w);
        chk("busy_addr", dm_addr, addr);
        chk("busy_wdata", dm_wdata, wdata);
        chk("busy_mw", mwWrite, 1'b0);
        chk("busy_stall", stall, !(b == ack_at || b == TO));
        @(posedge clk); #1;
        if (b == ack_at) begin
          acked = 1'b1;
          break;
        end
      end
      dm_ack   = 1'b0;
      exp_mem  = (acked && r && !w) ? rdata : 32'h0;
      exp_regw = acked ? rw : 1'b0;
      if (!acked) exp_err[1] = 1'b1;
    end
    check_wb(1'b1);
    chk("retire_req", dm_req, 1'b0);
    valid_in = 1'b0;
  endtask

  initial begin
    rst = 1'b0; valid_in = 1'b0; memR_in = 1'b0; memW_in = 1'b0;
    aluOut_in = '0; wrData_in = '0; gprDes_in = '0; regW_in = 1'b0;
    memToR_in = 1'b0; dm_ack = 1'b0; dm_rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_wb(1'b0);
    chk("rst_req", dm_req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    rst = 1'b1;

    run_instr(1'b0, 1'b0, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 0, 32'h0);
    idle(1'b0);
    run_instr(1'b1, 1'b0, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b1, 3, 32'hDEAD_BEEF);
    idle(1'b0);
    run_instr(1'b0, 1'b1, 32'h0000_0104, 32'hCAFE_F00D, 5'd9, 1'b0, 1'b0, 1, 32'h1111_2222);
    run_instr(1'b0, 1'b0, 32'h0000_0042, 32'h0, 5'd3, 1'b1, 1'b0, 0, 32'h0);
    idle(1'b0);
    run_instr(1'b1, 1'b0, 32'h0000_0102, 32'h0, 5'd4, 1'b1, 1'b1, 1, 32'h5555_5555);
    idle(1'b0);
    run_instr(1'b1, 1'b0, 32'h0000_0200, 32'h0, 5'd6, 1'b1, 1'b1, TO + 1, 32'h0);
    idle(1'b1);
    idle(1'b1);
    run_instr(1'b1, 1'b0, 32'h0000_0204, 32'h0, 5'd8, 1'b1, 1'b1, TO, 32'h0BAD_F00D);
    run_instr(1'b1, 1'b1, 32'h0000_0208, 32'h7777_8888, 5'd2, 1'b1, 1'b0, 2, 32'h9999_AAAA);

    // Reset during the second BUSY cycle of a load.
    valid_in = 1'b1; memR_in = 1'b1; memW_in = 1'b0; aluOut_in = 32'h300;
    gprDes_in = 5'd11; regW_in = 1'b1; memToR_in = 1'b1; dm_ack = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", dm_req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    check_wb(1'b0);
    chk("midrst_req", dm_req, 1'b0);
    chk("midrst_we", dm_we, 1'b0);
    chk("midrst_addr", dm_addr, 32'h0);
    chk("midrst_wdata", dm_wdata, 32'h0);
    idle(1'b1);
    run_instr(1'b0, 1'b0, 32'hABCD_0000, 32'h0, 5'd31, 1'b1, 1'b0, 0, 32'h0);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_instr(1'($urandom), 1'($urandom), a, $urandom, 5'($urandom),
                1'($urandom), 1'($urandom), $urandom_range(1, TO + 1), $urandom);
      if ($urandom_range(0, 2) == 0) idle(1'($urandom));
    end
    idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
